vga_sync: RTL and testbench

VGA timing generator for the brick-breaker display pipeline: it produces the `hpos`/`vpos` pixel coordinates and the sync/blanking signals for a 640x480 frame of 800x521 total pixels. `hpos`/`vpos` feed the per-pixel renderers directly, such as the brick colour stage that maps (`col`, `row`, `hpos`, `vpos`) to a 5-bit colour. `hsync`/`vsync` go to the VGA connector. It is the first stage of the video path; everything downstream samples its outputs on pixel ticks.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_sync_if.sv | 26 ++
 rtl/vga_pix_tick.sv | 40 ++++
 rtl/vga_sync.sv | 130 +++++++++++++
 tb/tb_vga_sync.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480 timing constants, derived
// totals, coordinate type and the startup state encoding. Also used by the
// brick colour renderer so both agree on the coordinate width.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 29;

  localparam int H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Every total must fit here; counters wrap by explicit compare, never overflow.
  localparam int COORD_W = 11;

  typedef logic [COORD_W-1:0] coord_t;

  // IDLE until the first pixel tick presents (0,0); RUN afterwards.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sync_state_t;

  // Inclusive window test used for the sync pulse decodes.
  function automatic logic in_span(coord_t pos, coord_t lo, coord_t hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Video timing bundle from vga_sync to the per-pixel renderers and the
// VGA connector. master = timing generator, slave = consumers.
interface vga_sync_if;
  import vga_pkg::*;

  logic         pix_tick;
  coord_t       hpos;
  coord_t       vpos;
  logic         hsync;
  logic         vsync;
  logic         display_en;
  logic         line_start;
  logic         frame_start;
  logic [7:0]   frame_cnt;

  modport master (
    output pix_tick, hpos, vpos, hsync, vsync,
           display_en, line_start, frame_start, frame_cnt
  );

  modport slave (
    input  pix_tick, hpos, vpos, hsync, vsync,
           display_en, line_start, frame_start, frame_cnt
  );

endinterface

// File: rtl/vga_pix_tick.sv
// Pixel-rate strobe source. With VGA_SYNC_CLKDIV_EN defined, clk runs at
// twice the pixel rate and a toggle enables every second edge (first tick on
// the 2nd edge after reset release). Otherwise clk is the pixel clock and
// every edge after reset is a pixel edge.
// tick_en: combinational, marks the coming clk edge as a pixel edge.
// pix_tick: registered copy, high in the cycle after such an edge.
module vga_pix_tick (
  input  logic clk,
  input  logic reset,
  output logic tick_en,
  output logic pix_tick
);

`ifdef VGA_SYNC_CLKDIV_EN
  logic phase_q;

  // Divide-by-two toggle; starts low so the first edge is skipped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_q <= 1'b0;
    else       phase_q <= ~phase_q;
  end

  assign tick_en = phase_q;

  // Registered strobe aligned with the counter updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pix_tick <= 1'b0;
    else       pix_tick <= phase_q;
  end
`else
  assign tick_en = 1'b1;

  // Strobe rises on the first edge after release and stays high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pix_tick <= 1'b0;
    else       pix_tick <= 1'b1;
  end
`endif

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: hpos/vpos counters, sync/blank decodes, line/frame
// strobes and a completed-frame counter. All outputs are registered from the
// same next-position values, so coordinates and decodes never skew.
// Optional clock divider selected by macro VGA_SYNC_CLKDIV_EN (see vga_pix_tick).
module vga_sync
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  vga_sync_if.master  vif
);

  localparam int LINE_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST   = coord_t'(LINE_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(FRAME_LINES - 1);
  localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
  localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic        tick_en;
  logic        pix_tick;

  sync_state_t state_q, state_d;
  coord_t      hpos_q, hpos_d;
  coord_t      vpos_q, vpos_d;
  logic [7:0]  fcnt_q, fcnt_d;

  logic        hsync_q, vsync_q, de_q, ls_q, fs_q;

  vga_pix_tick u_pix_tick (
    .clk      (clk),
    .reset    (reset),
    .tick_en  (tick_en),
    .pix_tick (pix_tick)
  );

  // Startup state register: cleared by reset, set by the first pixel tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and next position; the first tick presents (0,0) without counting.
  always_comb begin
    state_d = state_q;
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    fcnt_d  = fcnt_q;
    if (tick_en) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
          hpos_d  = '0;
          vpos_d  = '0;
        end
        default: begin
          if (hpos_q == H_LAST) begin
            hpos_d = '0;
            if (vpos_q == V_LAST) begin
              vpos_d = '0;
              fcnt_d = fcnt_q + 8'd1;
            end else begin
              vpos_d = vpos_q + coord_t'(1);
            end
          end else begin
            hpos_d = hpos_q + coord_t'(1);
          end
        end
      endcase
    end
  end

  // Position and frame counters; next values already hold between ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos_q <= '0;
      vpos_q <= '0;
      fcnt_q <= '0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Decodes registered from the next position; strobes last one tick only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      ls_q <= tick_en && (hpos_d == '0);
      fs_q <= tick_en && (hpos_d == '0) && (vpos_d == '0);
      if (tick_en) begin
        hsync_q <= in_span(hpos_d, HS_FIRST, HS_LAST) ? SYNC_POL : ~SYNC_POL;
        vsync_q <= in_span(vpos_d, VS_FIRST, VS_LAST) ? SYNC_POL : ~SYNC_POL;
        de_q    <= (hpos_d < H_VIS) && (vpos_d < V_VIS);
      end
    end
  end

  assign vif.pix_tick    = pix_tick;
  assign vif.hpos        = hpos_q;
  assign vif.vpos        = vpos_q;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.display_en  = de_q;
  assign vif.line_start  = ls_q;
  assign vif.frame_start = fs_q;
  assign vif.frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync using a reduced 16x8 timing so full frames and the
// 256-frame wrap fit in a short run. Expected outputs come from a model that
// derives every field from the running pixel-tick count.
module tb_vga_sync;
  import vga_pkg::*;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 1, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam bit POL = 1'b0;

  typedef logic [35:0] vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  vga_sync_if vif();

  vga_sync #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  vec_t exp_q[$];

  int unsigned m_n;
  vec_t        m_vec;
`ifdef VGA_SYNC_CLKDIV_EN
  bit          m_phase;
`endif

  int since = 0, fs_seen = 0, hs0 = 0, vs0 = 0, de0 = 0, debad = 0;

  function automatic vec_t mk(bit pix, int h, int v, bit hs, bit vs,
                              bit de, bit ls, bit fs, int fc);
    return {pix, 11'(h), 11'(v), hs, vs, de, ls, fs, 8'(fc)};
  endfunction

  function automatic vec_t obs();
    return {vif.pix_tick, vif.hpos, vif.vpos, vif.hsync, vif.vsync,
            vif.display_en, vif.line_start, vif.frame_start, vif.frame_cnt};
  endfunction

  function automatic vec_t reset_vec();
    return mk(1'b0, 0, 0, ~POL, ~POL, 1'b0, 1'b0, 1'b0, 0);
  endfunction

  task automatic model_reset();
    m_n   = 0;
    m_vec = reset_vec();
`ifdef VGA_SYNC_CLKDIV_EN
    m_phase = 1'b0;
`endif
  endtask

  task automatic model_advance();
    bit mt;
    int p, h, v;
`ifdef VGA_SYNC_CLKDIV_EN
    mt      = m_phase;
    m_phase = ~m_phase;
`else
    mt = 1'b1;
`endif
    if (mt) begin
      m_n++;
      p = int'(m_n) - 1;
      h = p % HT;
      v = (p / HT) % VT;
      m_vec = mk(1'b1, h, v,
                 (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL,
                 (v >= VA + VF && v < VA + VF + VS) ? POL : ~POL,
                 (h < HA) && (v < VA), h == 0, (h == 0) && (v == 0),
                 (p / FT) % 256);
    end else begin
      m_vec[35] = 1'b0;
      m_vec[9]  = 1'b0;
      m_vec[8]  = 1'b0;
    end
  endtask

  task automatic check_top(string tag);
    vec_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s scoreboard empty observed=%h", tag, obs());
    end else begin
      e = exp_q.pop_front();
      assert (obs() === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs(), e);
      end
    end
  endtask

  task automatic chk_int(string tag, int o, int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_advance();
    exp_q.push_back(m_vec);
    #1;
    check_top("cycle");
  endtask

  task automatic tally();
    if (vif.pix_tick) begin
      if (vif.frame_start) begin
        if (fs_seen > 0) chk_int("fs_spacing", since, FT);
        if (fs_seen == 1) chk_int("frame_cnt_after1", int'(vif.frame_cnt), 1);
        since = 0;
        fs_seen++;
      end
      since++;
      if (fs_seen == 1) begin
        if (vif.vpos == 0 && vif.hsync == POL) hs0++;
        if (vif.vsync == POL) vs0++;
        if (vif.display_en) de0++;
      end
      if (vif.display_en && int'(vif.vpos) >= VA) debad++;
    end
  endtask

  initial begin
    bit got;
    int guard;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(reset_vec());
    check_top("reset_state");

    @(negedge clk);
    reset = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      step();
      tally();
      if (vif.pix_tick) got = 1'b1;
    end
    exp_q.push_back(mk(1'b1, 0, 0, ~POL, ~POL, 1'b1, 1'b1, 1'b1, 0));
    check_top("first_tick");

    guard = 0;
    while (fs_seen < 257 && guard < 2 * FT * 258 + 16) begin
      step();
      tally();
      guard++;
    end
    chk_int("fs_count", fs_seen, 257);
    chk_int("frame_cnt_wrap", int'(vif.frame_cnt), 0);
    chk_int("hsync_width", hs0, HS);
    chk_int("vsync_ticks", vs0, VS * HT);
    chk_int("de_pixels", de0, HA * VA);
    chk_int("de_blank_rows", debad, 0);

    guard = 0;
    while (!(m_vec[35] && m_vec[34:24] == 11'd5 && m_vec[23:13] == 11'd3)
           && guard < 2 * FT) begin
      step();
      guard++;
    end
    chk_int("reach_5_3", int'(vif.hpos) * 100 + int'(vif.vpos), 503);

    @(negedge clk);
    reset = 1'b1;
    #1;
    exp_q.push_back(reset_vec());
    check_top("reset_async");
    @(posedge clk);
    #1;
    exp_q.push_back(reset_vec());
    check_top("reset_hold");

    @(negedge clk);
    reset = 1'b0;
    model_reset();
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      step();
      if (vif.pix_tick) got = 1'b1;
    end
    exp_q.push_back(mk(1'b1, 0, 0, ~POL, ~POL, 1'b1, 1'b1, 1'b1, 0));
    check_top("restart_origin");

    for (int i = 0; i < 2 * HT + 4; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
